// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and defaults for the LSU memory master.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int unsigned LSU_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

    // Illegal size or a half/word access that straddles its natural boundary.
    function automatic logic lsu_bad_access(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data placement and load extract with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [7:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [4:0]  shamt;
    logic [31:0] rshift;

    assign shamt  = {off_i, 3'b000};
    assign rshift = mem_rdata_i >> shamt;

    always_comb begin
        wmask_o = '0;
        wdata_o = '0;
        case (size_i)
            SZ_B: begin
                wmask_o = 8'h01 << off_i;
                wdata_o = {24'b0, wdata_i[7:0]} << shamt;
            end
            SZ_H: begin
                wmask_o = 8'h03 << off_i;
                wdata_o = {16'b0, wdata_i[15:0]} << shamt;
            end
            SZ_W: begin
                wmask_o = 8'h0F;
                wdata_o = wdata_i;
            end
            default: begin
                wmask_o = '0;
                wdata_o = '0;
            end
        endcase
    end

    always_comb begin
        rdata_o = rshift;
        case (size_i)
            SZ_B:    rdata_o = {{24{~unsigned_i & rshift[7]}}, rshift[7:0]};
            SZ_H:    rdata_o = {{16{~unsigned_i & rshift[15]}}, rshift[15:0]};
            default: rdata_o = rshift;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory initiator: one request at a time onto the SRAM strobe port.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = LSU_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          wr_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;

    logic          accept;
    logic          in_access;
    logic [7:0]    al_wmask;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;

    lsu_align u_align (
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .off_i       (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .mem_rdata_i (mem_rdata),
        .wmask_o     (al_wmask),
        .wdata_o     (al_wdata),
        .rdata_o     (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= req_wr;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (lsu_bad_access(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Completion is checked before the timeout so a last-cycle mem_valid still succeeds.
                if (mem_valid) begin
                    rdata_d = wr_q ? '0 : al_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_access  = (state_q == ACCESS);
    assign req_ready  = (state_q == IDLE) && rst;

    assign mem_ren    = in_access && !wr_q;
    assign mem_wen    = in_access && wr_q;
    assign mem_addr   = in_access ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata  = (in_access && wr_q) ? al_wdata : '0;
    assign mem_wmask  = (in_access && wr_q) ? al_wmask : '0;

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomised and directed bench for lsu_mem_master against a transaction-timeline model.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk, rst;
    logic        req_valid, req_ready, req_wr, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_ren, mem_wen, mem_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    lsu_mem_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Current transaction as seen by the model (written by the driver only).
    logic        busy = 1'b0;
    logic        m_wr, m_uns, m_bad, m_to;
    int          m_size, m_delay, m_hold, m_m;
    logic [31:0] m_addr, m_wdata;
    int          t_acc = 0, t_resp = 0;
    logic        spur_en = 1'b0;
    logic        rd_fix_en = 1'b0;
    logic [31:0] rd_fix = '0;
    logic        lit_en = 1'b0;
    logic [31:0] lit_addr, lit_wdata, lit_rdata;
    logic [7:0]  lit_wmask;
    logic        lit_err;
    int          lit_cnt;

    logic [31:0] done_rdata = '0;
    int          errors = 0, checks = 0;
    int          scnt = 0;

    function automatic logic [31:0] load_model(input logic [31:0] rd, input int off,
                                               input int size, input logic uns);
        int unsigned b[4];
        longint v;
        for (int i = 0; i < 4; i++) b[i] = int'(rd[8*i +: 8]);
        if (size == 0) begin
            v = b[off];
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = b[off] + 256 * b[off+1];
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(rd);
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] d, input int off, input int size);
        int n;
        n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        if (n == 4) return d;
        return (d & ((32'd1 << (8*n)) - 32'd1)) << (8*off);
    endfunction

    function automatic logic [7:0] store_mask(input int off, input int size);
        int n;
        n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        return 8'(((1 << n) - 1) << off);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // Memory and response-side environment, driven 2 ns after each edge.
    always @(posedge clk) begin
        logic inwin;
        #2;
        inwin = busy && !m_bad && cyc >= t_acc && cyc < t_acc + m_m;
        mem_rdata = rd_fix_en ? rd_fix : $urandom;
        if (inwin) begin
            mem_valid = (cyc == t_acc + m_delay);
            if (mem_valid) done_rdata = mem_rdata;
        end else begin
            mem_valid = spur_en ? 1'($urandom % 2) : 1'b0;
        end
        if (busy && cyc >= t_resp) resp_ready = (cyc == t_resp + m_hold);
        else resp_ready = 1'($urandom % 2);
    end

    // Single compare process on the falling edge.
    always @(negedge clk) begin
        logic acc, rsp;
        logic [31:0] exp_rd;
        if (cyc >= 1) begin
            acc = busy && !m_bad && cyc >= t_acc && cyc < t_acc + m_m;
            rsp = busy && cyc >= t_resp && cyc <= t_resp + m_hold;
            exp_rd = (m_bad || m_to || m_wr) ? 32'h0 : load_model(done_rdata, int'(m_addr[1:0]), m_size, m_uns);
            chk("req_ready", 32'(req_ready), 32'(rst && !(busy && cyc >= t_acc)));
            chk("mem_ren", 32'(mem_ren), 32'(acc && !m_wr));
            chk("mem_wen", 32'(mem_wen), 32'(acc && m_wr));
            chk("mem_addr", mem_addr, acc ? (m_addr & 32'hFFFF_FFFC) : 32'h0);
            chk("mem_wdata", mem_wdata, (acc && m_wr) ? store_data(m_wdata, int'(m_addr[1:0]), m_size) : 32'h0);
            chk("mem_wmask", 32'(mem_wmask), (acc && m_wr) ? 32'(store_mask(int'(m_addr[1:0]), m_size)) : 32'h0);
            chk("resp_valid", 32'(resp_valid), 32'(rsp));
            if (acc && lit_en) begin
                chk("lit_addr", mem_addr, lit_addr);
                if (m_wr) begin
                    chk("lit_wdata", mem_wdata, lit_wdata);
                    chk("lit_wmask", 32'(mem_wmask), 32'(lit_wmask));
                end
            end
            if (mem_ren || mem_wen) scnt++;
            if (rsp) begin
                chk("resp_err", 32'(resp_err), 32'(m_bad || m_to));
                chk("resp_rdata", resp_rdata, exp_rd);
                if (resp_ready) begin
                    chk("strobe_cycles", 32'(scnt), 32'(m_m));
                    if (lit_en) begin
                        chk("lit_rdata", resp_rdata, lit_rdata);
                        chk("lit_err", 32'(resp_err), 32'(lit_err));
                        chk("lit_cnt", 32'(scnt), 32'(lit_cnt));
                    end
                    scnt = 0;
                end
            end
            if (!rst) scnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic wr, input int size, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input int delay, input int hold, input int rst_at);
        m_wr = wr; m_size = size; m_uns = uns; m_addr = addr; m_wdata = wdata;
        m_delay = delay; m_hold = hold;
        m_bad = (size == 3) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00);
        m_to  = !m_bad && delay >= int'(TO);
        m_m   = m_bad ? 0 : (delay < int'(TO) ? delay + 1 : int'(TO));
        t_acc = cyc + 1;
        t_resp = m_bad ? t_acc : t_acc + m_m;
        req_wr = wr; req_size = 2'(size); req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        busy = 1'b1;
        step();
        req_valid = 1'b0;
        req_wr = 1'($urandom % 2); req_size = 2'($urandom % 4);
        req_addr = $urandom; req_wdata = $urandom;
        if (rst_at > 0) begin
            repeat (rst_at - 1) step();
            rst = 1'b0;
            step();
            busy = 1'b0;
            step();
            rst = 1'b1;
            step();
        end else begin
            while (cyc <= t_resp + m_hold) step();
            busy = 1'b0;
        end
    endtask

    task automatic set_lit(input logic [31:0] a, input logic [31:0] wd, input logic [7:0] wm,
                           input logic [31:0] rd, input logic e, input int c);
        lit_en = 1'b1; lit_addr = a; lit_wdata = wd; lit_wmask = wm;
        lit_rdata = rd; lit_err = e; lit_cnt = c;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_valid = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
        m_wr = 1'b0; m_uns = 1'b0; m_bad = 1'b0; m_to = 1'b0; m_size = 0; m_delay = 0;
        m_hold = 0; m_m = 0; m_addr = '0; m_wdata = '0;
        lit_addr = '0; lit_wdata = '0; lit_wmask = '0; lit_rdata = '0; lit_err = 1'b0; lit_cnt = 0;
        repeat (3) step();
        rst = 1'b1;
        step();

        rd_fix_en = 1'b1;
        rd_fix = 32'hDEADBEEF;
        set_lit(32'h8000_0004, 32'h0, 8'h0, 32'hDEADBEEF, 1'b0, 1);
        txn(1'b0, 2, 1'b0, 32'h8000_0004, 32'h0, 0, 0, 0);
        step();
        rd_fix = 32'h80FF1234;
        set_lit(32'h8000_0000, 32'h0, 8'h0, 32'hFFFFFF80, 1'b0, 2);
        txn(1'b0, 0, 1'b0, 32'h8000_0003, 32'h0, 1, 1, 0);
        set_lit(32'h8000_0000, 32'h0, 8'h0, 32'h00000080, 1'b0, 1);
        txn(1'b0, 0, 1'b1, 32'h8000_0003, 32'h0, 0, 0, 0);
        set_lit(32'h8000_0000, 32'h0, 8'h0, 32'h000080FF, 1'b0, 3);
        txn(1'b0, 1, 1'b1, 32'h8000_0002, 32'h0, 2, 3, 0);
        set_lit(32'h8000_0000, 32'h0000AB00, 8'h02, 32'h0, 1'b0, 1);
        txn(1'b1, 0, 1'b0, 32'h8000_0001, 32'h0000_00AB, 0, 0, 0);
        set_lit(32'h0, 32'h0, 8'h0, 32'h0, 1'b1, 0);
        txn(1'b0, 2, 1'b0, 32'h8000_0002, 32'h0, 0, 0, 0);
        txn(1'b1, 3, 1'b0, 32'h8000_0000, 32'h1234_5678, 0, 2, 0);
        set_lit(32'h8000_0010, 32'h0, 8'h0, 32'h0, 1'b1, 4);
        txn(1'b0, 2, 1'b0, 32'h8000_0010, 32'h0, 100, 1, 0);
        set_lit(32'h8000_0010, 32'h0, 8'h0, 32'h80FF1234, 1'b0, 4);
        txn(1'b0, 2, 1'b0, 32'h8000_0010, 32'h0, int'(TO) - 1, 3, 0);
        lit_en = 1'b0;
        rd_fix_en = 1'b0;
        txn(1'b0, 2, 1'b0, 32'h8000_0020, 32'h0, 10, 0, 2);

        spur_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int sz;
            a = $urandom;
            sz = ($urandom % 8 == 0) ? 3 : int'($urandom % 3);
            if ($urandom % 4 != 0) begin
                if (sz == 1) a[0] = 1'b0;
                if (sz == 2) a[1:0] = 2'b00;
            end
            txn(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom,
                int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                ($urandom % 25 == 0) ? 1 : 0);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
